reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Consumes the synchronized reset produced by the reset synchronizer and releases
//  the accelerator's reset domains in a fixed order: weight/state memories, then
//  neuron core, then AXI-Stream spike I/O. Requires a memory-init handshake
//  between the memory and core releases. Supports a soft reset from the
//  AXI-Lite control block, which asserts the domains in reverse order.
// PARAMETERS
//  HOLD_CYCLES   16    cycles all domains stay in reset after rst_n is sampled high
//  STAGE_GAP     4     cycles between successive domain release/assert steps (>=1)
//  INIT_TIMEOUT  1024  max cycles to wait for mem_init_done before forcing progress
// PORTS
//  clk               in   1  single system clock
//  rst_n             in   1  synchronous active-low reset, driven from the synchronizer output
//  soft_rst_req      in   1  one-cycle soft reset request from the control regs
//  mem_init_done     in   1  level; memory init complete
//  mem_rst_n         out  1  memory domain reset, active low
//  mem_init_start    out  1  one-cycle pulse: start memory clear/init
//  core_rst_n        out  1  neuron core domain reset, active low
//  axis_rst_n        out  1  AXIS spike I/O domain reset, active low
//  rst_busy          out  1  high whenever any domain is in reset or a sequence is running
//  init_timeout_err  out  1  sticky: mem_init_done was not seen within INIT_TIMEOUT
// BEHAVIOUR
//  - rst_n is sampled only on posedge clk. When rst_n=0: state=HOLD, counter=0,
//    mem/core/axis_rst_n=0, mem_init_start=0, rst_busy=1, init_timeout_err=0.
//  - FSM states: HOLD, MEM_INIT, CORE_GAP, AXIS_GAP, RUN, SOFT_AXIS, SOFT_CORE, SOFT_MEM.
//  - HOLD: count HOLD_CYCLES edges with rst_n=1. Then go to MEM_INIT.
//    On that edge mem_rst_n->1 and mem_init_start->1 for exactly one cycle.
//  - MEM_INIT: mem_init_done is sampled only from the edge after the start pulse.
//    A level already high before then is ignored. If done is sampled high, go to
//    CORE_GAP. If INIT_TIMEOUT cycles elapse after the start, set init_timeout_err
//    and go to CORE_GAP. If done and timeout occur on the same edge, done wins
//    and err is not set.
//  - CORE_GAP: after STAGE_GAP edges, core_rst_n->1 and go to AXIS_GAP.
//  - AXIS_GAP: after STAGE_GAP edges, axis_rst_n->1, rst_busy->0, go to RUN.
//  - RUN: soft_rst_req=1 -> same edge axis_rst_n->0, rst_busy->1, go to SOFT_AXIS.
//  - SOFT_AXIS: after STAGE_GAP edges, core_rst_n->0, go to SOFT_CORE.
//  - SOFT_CORE: after STAGE_GAP edges, mem_rst_n->0, go to SOFT_MEM.
//  - SOFT_MEM: go to HOLD on the next edge; the full release sequence then repeats.
//  - Soft reset does not clear init_timeout_err. Only rst_n=0 clears it.
//  - soft_rst_req outside RUN is ignored (not queued).
//  - rst_n=0 in any state overrides everything on the same edge.
//  - Invariant: mem released <= core released <= axis released. A domain never
//    releases before an upstream domain. All outputs are registered (no
//    combinational paths from inputs).
//  - One shared counter, width $clog2(max(HOLD_CYCLES,STAGE_GAP,INIT_TIMEOUT)+1).
//    It clears on every state change and saturates, never wrapping.
// STRUCTURE
//  - Shared header snn_reset_defs.vh: FSM state localparams (3-bit encoding),
//    and default timing constants shared with the top level and testbench.
//  - One sub-module, rst_stage_timer: load/count/expire counter with
//    terminal-count flag. It is reused by all timed states.
// TESTING (defaults; edge 0 = first posedge with rst_n sampled 1)
//  1. Release, with done pulsed 10 edges after the start pulse -> mem_rst_n and
//     mem_init_start at edge 16; core_rst_n at 30; axis_rst_n=1 and rst_busy=0 at 34.
//  2. mem_init_done held 0 -> init_timeout_err=1 at edge 16+1024. core_rst_n 4
//     edges later, axis 8 edges later. err stays high through a later soft reset.
//  3. In RUN, soft_rst_req at edge T -> axis_rst_n=0 at T, core_rst_n=0 at T+4,
//     mem_rst_n=0 at T+8, HOLD at T+9. Re-release mem_rst_n at T+25.
//  4. rst_n=0 during MEM_INIT and during SOFT_CORE -> all outputs at reset values
//     on the next edge. The sequence restarts cleanly when rst_n returns to 1.
//  5. mem_init_done rises on the same edge as timeout expiry -> no err, and
//     normal core release. done already high before the start pulse -> ignored.
//  6. soft_rst_req pulsed during HOLD and during AXIS_GAP -> no effect on
//     sequence timing.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared FSM state encoding, default timing constants and counter sizing for the reset sequencer.
// Imported by the sequencer top and its testbench.
package reset_sequencer_pkg;

  localparam int HOLD_CYCLES_DEF  = 16;
  localparam int STAGE_GAP_DEF    = 4;
  localparam int INIT_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_MEM_INIT  = 3'd1,
    ST_CORE_GAP  = 3'd2,
    ST_AXIS_GAP  = 3'd3,
    ST_RUN       = 3'd4,
    ST_SOFT_AXIS = 3'd5,
    ST_SOFT_CORE = 3'd6,
    ST_SOFT_MEM  = 3'd7
  } state_t;

  // Bits needed to hold the largest terminal count without wrapping.
  function automatic int cnt_width(input int hold, input int gap, input int tmo);
    int m;
    m = hold;
    if (gap > m) m = gap;
    if (tmo > m) m = tmo;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_stage_timer.sv
// Load/count/expire timer shared by every timed sequencer state; saturates at all-ones.
// Latency: count is registered, expired follows the count combinationally; no backpressure.
module reset_sequencer_stage_timer #(
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic [CW-1:0] terminal,
  output logic          expired
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != {CW{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt >= terminal);

endmodule

// File: rtl/reset_sequencer.sv
// Releases memory, core and AXIS reset domains in order after reset, with a memory-init handshake;
// soft reset re-asserts them in reverse. All outputs registered; no backpressure on inputs.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
  parameter int STAGE_GAP    = STAGE_GAP_DEF,
  parameter int INIT_TIMEOUT = INIT_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic soft_rst_req,
  input  logic mem_init_done,
  output logic mem_rst_n,
  output logic mem_init_start,
  output logic core_rst_n,
  output logic axis_rst_n,
  output logic rst_busy,
  output logic init_timeout_err
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP, INIT_TIMEOUT);

  state_t        state;
  logic [CW-1:0] terminal;
  logic [CW-1:0] load_val;
  logic          expired;
  logic          leave;

  // HOLD counts every rst_n-high edge it sees; the other states fire on their Nth edge.
  always_comb begin
    terminal = CW'(STAGE_GAP - 1);
    case (state)
      ST_HOLD:     terminal = CW'(HOLD_CYCLES);
      ST_MEM_INIT: terminal = CW'(INIT_TIMEOUT - 1);
      default:     terminal = CW'(STAGE_GAP - 1);
    endcase
  end

  always_comb begin
    leave = 1'b0;
    case (state)
      ST_RUN:      leave = soft_rst_req;
      ST_MEM_INIT: leave = mem_init_done | expired;
      ST_SOFT_MEM: leave = 1'b1;
      default:     leave = expired;
    endcase
  end

  // The SOFT_MEM->HOLD edge already has rst_n high, so it is the first counted hold edge.
  assign load_val = (state == ST_SOFT_MEM) ? CW'(1) : '0;

  reset_sequencer_stage_timer #(
    .CW(CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (leave),
    .load_val (load_val),
    .terminal (terminal),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_HOLD;
      mem_rst_n        <= 1'b0;
      core_rst_n       <= 1'b0;
      axis_rst_n       <= 1'b0;
      mem_init_start   <= 1'b0;
      rst_busy         <= 1'b1;
      init_timeout_err <= 1'b0;
    end else begin
      mem_init_start <= 1'b0;
      if (leave) begin
        case (state)
          ST_HOLD: begin
            state          <= ST_MEM_INIT;
            mem_rst_n      <= 1'b1;
            mem_init_start <= 1'b1;
          end
          ST_MEM_INIT: begin
            state <= ST_CORE_GAP;
            // A done seen on the expiry edge still counts as a clean init.
            if (!mem_init_done) init_timeout_err <= 1'b1;
          end
          ST_CORE_GAP: begin
            state      <= ST_AXIS_GAP;
            core_rst_n <= 1'b1;
          end
          ST_AXIS_GAP: begin
            state      <= ST_RUN;
            axis_rst_n <= 1'b1;
            rst_busy   <= 1'b0;
          end
          ST_RUN: begin
            state      <= ST_SOFT_AXIS;
            axis_rst_n <= 1'b0;
            rst_busy   <= 1'b1;
          end
          ST_SOFT_AXIS: begin
            state      <= ST_SOFT_CORE;
            core_rst_n <= 1'b0;
          end
          ST_SOFT_CORE: begin
            state     <= ST_SOFT_MEM;
            mem_rst_n <= 1'b0;
          end
          ST_SOFT_MEM: begin
            state <= ST_HOLD;
          end
          default: begin
            state <= ST_HOLD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: vector table, hand-written timeout/reset sequences,
// and random stimulus against an event-schedule reference model.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  localparam int HOLD = HOLD_CYCLES_DEF;
  localparam int GAP  = STAGE_GAP_DEF;
  localparam int TMO  = INIT_TIMEOUT_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic soft_rst_req = 1'b0;
  logic mem_init_done = 1'b0;
  logic mem_rst_n, mem_init_start, core_rst_n, axis_rst_n, rst_busy, init_timeout_err;

  int checks = 0;
  int errors = 0;

  reset_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .soft_rst_req     (soft_rst_req),
    .mem_init_done    (mem_init_done),
    .mem_rst_n        (mem_rst_n),
    .mem_init_start   (mem_init_start),
    .core_rst_n       (core_rst_n),
    .axis_rst_n       (axis_rst_n),
    .rst_busy         (rst_busy),
    .init_timeout_err (init_timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: absolute edge times of scheduled events, -1 when nothing is pending.
  int  n = 0;
  int  rel_at = -1, init_at = -1, core_at = -1, axis_at = -1, coff_at = -1, moff_at = -1;
  bit  running = 0;
  bit  m_mem = 0, m_start = 0, m_core = 0, m_axis = 0, m_busy = 1, m_err = 0;

  task automatic model_edge(input bit r, input bit s, input bit d);
    n++;
    m_start = 1'b0;
    if (!r) begin
      m_mem = 0; m_core = 0; m_axis = 0; m_busy = 1; m_err = 0; running = 0;
      rel_at = n + 1 + HOLD;
      init_at = -1; core_at = -1; axis_at = -1; coff_at = -1; moff_at = -1;
    end else if (n == rel_at) begin
      m_mem = 1; m_start = 1; init_at = n; rel_at = -1;
    end else if (init_at >= 0) begin
      if (d) begin
        core_at = n + GAP; init_at = -1;
      end else if (n == init_at + TMO) begin
        m_err = 1; core_at = n + GAP; init_at = -1;
      end
    end else if (n == core_at) begin
      m_core = 1; core_at = -1; axis_at = n + GAP;
    end else if (n == axis_at) begin
      m_axis = 1; m_busy = 0; running = 1; axis_at = -1;
    end else if (running && s) begin
      m_axis = 0; m_busy = 1; running = 0;
      coff_at = n + GAP; moff_at = n + 2 * GAP; rel_at = n + 2 * GAP + 1 + HOLD;
    end else if (n == coff_at) begin
      m_core = 0; coff_at = -1;
    end else if (n == moff_at) begin
      m_mem = 0; moff_at = -1;
    end
  endtask

  task automatic tick(input bit r, input bit s, input bit d);
    rst_n = r; soft_rst_req = s; mem_init_done = d;
    @(posedge clk);
    model_edge(r, s, d);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b (edge %0d)", nm, act, req, n);
    end
  endtask

  // Bit order: mem_rst_n, mem_init_start, core_rst_n, axis_rst_n, rst_busy, init_timeout_err
  function automatic logic [5:0] outs();
    return {mem_rst_n, mem_init_start, core_rst_n, axis_rst_n, rst_busy, init_timeout_err};
  endfunction

  task automatic chk_vec(input string nm, input int idx, input logic [5:0] req);
    checks++;
    if (outs() !== req) begin
      errors++;
      $display("FAIL %s[%0d]: outputs %b expected %b (edge %0d)", nm, idx, outs(), req, n);
    end
  endtask

  typedef struct {
    int         cyc;
    bit         r, s, d;
    logic [5:0] expv;
  } vec_t;

  localparam logic [5:0] RV = 6'b000010;

  initial begin
    vec_t tbl[$];
    int   r_lim, d_lim;
    bit   rr, ss, dd;

    // Release sequence with soft pulses in HOLD and AXIS_GAP, a soft reset in RUN,
    // and a stale done level before the second start pulse.
    tbl.push_back('{3,  0, 0, 0, RV});
    tbl.push_back('{5,  1, 0, 0, RV});
    tbl.push_back('{1,  1, 1, 0, RV});
    tbl.push_back('{10, 1, 0, 0, RV});
    tbl.push_back('{1,  1, 0, 0, 6'b110010});   // edge 16
    tbl.push_back('{1,  1, 0, 0, 6'b100010});
    tbl.push_back('{8,  1, 0, 0, 6'b100010});
    tbl.push_back('{1,  1, 0, 1, 6'b100010});   // done at edge 26
    tbl.push_back('{3,  1, 0, 0, 6'b100010});
    tbl.push_back('{1,  1, 0, 0, 6'b101010});   // core at 30
    tbl.push_back('{1,  1, 0, 0, 6'b101010});
    tbl.push_back('{1,  1, 1, 0, 6'b101010});
    tbl.push_back('{1,  1, 0, 0, 6'b101010});
    tbl.push_back('{1,  1, 0, 0, 6'b101100});   // axis at 34
    tbl.push_back('{5,  1, 0, 0, 6'b101100});
    tbl.push_back('{1,  1, 1, 0, 6'b101010});   // soft at T=40
    tbl.push_back('{3,  1, 0, 0, 6'b101010});
    tbl.push_back('{1,  1, 0, 0, 6'b100010});   // T+4
    tbl.push_back('{3,  1, 0, 0, 6'b100010});
    tbl.push_back('{1,  1, 0, 0, 6'b000010});   // T+8
    tbl.push_back('{16, 1, 0, 1, 6'b000010});
    tbl.push_back('{1,  1, 0, 1, 6'b110010});   // T+25
    tbl.push_back('{4,  1, 0, 0, 6'b100010});
    tbl.push_back('{1,  1, 0, 1, 6'b100010});
    tbl.push_back('{3,  1, 0, 0, 6'b100010});
    tbl.push_back('{1,  1, 0, 0, 6'b101010});

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].cyc; c++) begin
        tick(tbl[i].r, tbl[i].s, tbl[i].d);
        chk_vec("table", i, tbl[i].expv);
      end
    end

    // Init timeout, then a soft reset that must leave the error flag set.
    tick(0, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < 1040; i++) tick(1, 0, 0);
    chk("tmo_err_before", init_timeout_err, 1'b0);
    tick(1, 0, 0);
    chk("tmo_err_at_1040", init_timeout_err, 1'b1);
    chk("tmo_core_at_1040", core_rst_n, 1'b0);
    repeat (3) tick(1, 0, 0);
    chk("tmo_core_before_1044", core_rst_n, 1'b0);
    tick(1, 0, 0);
    chk("tmo_core_at_1044", core_rst_n, 1'b1);
    chk("tmo_axis_at_1044", axis_rst_n, 1'b0);
    repeat (4) tick(1, 0, 0);
    chk_vec("tmo_run_1048", 0, 6'b101101);
    tick(1, 1, 0);
    repeat (30) tick(1, 0, 0);
    chk_vec("tmo_after_soft", 0, 6'b100011);

    // Done arriving on the timeout edge wins.
    tick(0, 0, 0);
    for (int i = 0; i < 1040; i++) tick(1, 0, 0);
    tick(1, 0, 1);
    chk("tie_err", init_timeout_err, 1'b0);
    repeat (3) tick(1, 0, 0);
    chk("tie_core_before", core_rst_n, 1'b0);
    tick(1, 0, 0);
    chk("tie_core_1044", core_rst_n, 1'b1);
    chk("tie_err_1044", init_timeout_err, 1'b0);

    // rst_n during MEM_INIT, then during SOFT_CORE.
    tick(0, 0, 0);
    repeat (20) tick(1, 0, 0);
    tick(0, 0, 0);
    chk_vec("rst_in_init", 0, RV);
    repeat (16) tick(1, 0, 0);
    chk("restart_mem_hold", mem_rst_n, 1'b0);
    tick(1, 0, 0);
    chk_vec("restart_mem_rel", 0, 6'b110010);
    tick(1, 0, 1);
    repeat (8) tick(1, 0, 0);
    chk_vec("restart_run", 0, 6'b101100);
    tick(1, 1, 0);
    repeat (5) tick(1, 0, 0);
    chk_vec("in_soft_core", 0, 6'b100010);
    tick(0, 0, 0);
    chk_vec("rst_in_soft_core", 0, RV);
    repeat (17) tick(1, 0, 0);
    chk_vec("restart2_mem_rel", 0, 6'b110010);

    // Random stimulus against the schedule model; second half makes done rare to reach timeouts.
    tick(0, 0, 0);
    chk_vec("rand_reset", 0, {m_mem, m_start, m_core, m_axis, m_busy, m_err});
    for (int i = 0; i < 9000; i++) begin
      r_lim = (i < 4000) ? 299 : 4999;
      d_lim = (i < 4000) ? 6 : 1500;
      rr = ($urandom_range(0, r_lim) != 0);
      ss = ($urandom_range(0, 15) == 0);
      dd = ($urandom_range(0, d_lim) == 0);
      tick(rr, ss, dd);
      chk_vec("random", i, {m_mem, m_start, m_core, m_axis, m_busy, m_err});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
